oled_frame_streamer: RTL
========================

Name: oled_frame_streamer

Overview:
- Upstream feeder for the OLED controller's ACTIVE-mode interface (data_type / byte_count / send_bytes / spi_done).
- On a frame trigger, it sends one address-window command burst.
- It then streams a WIDTH×HEIGHT RGB565 framebuffer as pixel-data bursts.
- Pixels are read from a 1-cycle-latency framebuffer RAM port and packed up to PIX_PER_BURST pixels per burst.

Parameters:
- WIDTH, 96, display columns.
- HEIGHT, 64, display rows.
- PIX_PER_BURST, 7, pixels per data burst; 2*PIX_PER_BURST must be ≤ 15.
- AW, $clog2(WIDTH*HEIGHT) = 13, framebuffer address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle request to send one frame.
- busy  out  1  high from accepted frame_start until frame_done.
- frame_done  out  1  single-cycle pulse after the last data burst is acknowledged.
- pix_addr  out  AW  framebuffer read address, row-major.
- pix_data  in  16  RGB565; valid one cycle after pix_addr.
- spi_done  in  1  controller pulse: current burst transmitted.
- data_type  out  1  0 = command, 1 = data.
- byte_count  out  4  bytes in current burst; 0 = nothing to send.
- send_bytes  out  120  burst payload.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; busy=0, frame_done=0, pix_addr=0, data_type=0, byte_count=0, send_bytes=0, pixel index=0. Reset mid-frame aborts immediately with no completion pulse.
- Packing: transmitted byte k occupies send_bytes[119-8k -: 8]. Unused low bytes are 0. Each pixel is sent as its high byte, then its low byte.
- Outputs are registered. byte_count is nonzero only in ADDR and SEND; it is 0 in all other states.
- IDLE:
  - All burst outputs are 0.
  - frame_start=1 → ADDR, busy=1 on the next cycle.
- ADDR:
  - data_type=0, byte_count=6.
  - Bytes: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1 (0x15 00 5F 75 00 3F at defaults).
  - Outputs are held stable until spi_done=1, then → FETCH.
- FETCH:
  - n = min(PIX_PER_BURST, WIDTH*HEIGHT − idx).
  - Issues pix_addr = idx .. idx+n−1 on consecutive cycles and captures pix_data one cycle after each address.
  - Lasts n+1 cycles, then → SEND with byte_count=2n and data_type=1.
  - byte_count=0 throughout FETCH.
- SEND:
  - Holds data_type, byte_count and send_bytes stable until spi_done.
  - On spi_done: idx += n. If idx = WIDTH*HEIGHT → DONE, else → FETCH.
- DONE: one cycle with frame_done=1, busy=0 and outputs cleared; idx=0; → IDLE.
- frame_start while busy=1 is ignored; it is not queued.
- spi_done in IDLE, FETCH or DONE is ignored.
- spi_done coinciding with frame_start in IDLE: only frame_start acts.
- At defaults: 6144 pixels = 877 full bursts of 14 bytes plus a final burst of 5 pixels (byte_count=10).
- pix_addr never exceeds WIDTH*HEIGHT−1.
- Throughput bound: 878 data bursts per frame, plus 1 command burst.

Test Plan:
- Reset: hold rst=0 mid-clock → all outputs 0 asynchronously. Release, with no frame_start for 100 cycles → byte_count stays 0 and busy=0.
- Frame start: frame_start pulse, spi_done returned 5 cycles after each burst appears → first burst is data_type=0, byte_count=6, send_bytes[119:72]=0x15005F75003F. Exactly 878 data bursts follow, then frame_done pulses once.
- Byte order: model RAM with pix_data=address → first data burst send_bytes[119:8]=0x0000_0001_0002_0003_0004_0005_0006 and send_bytes[7:0]=0. The last burst has byte_count=10, first pixel 0x17FB, and its low 40 bits are 0.
- Stall: delay spi_done by 1000 cycles in a SEND → outputs are bit-identical every cycle until spi_done. With spi_done at zero delay, bursts still advance correctly.
- Ignored trigger: frame_start pulsed during FETCH and SEND → no restart, still 878 data bursts. A second frame_start after frame_done → new ADDR burst, pix_addr restarts at 0.
- Mid-frame reset: assert rst=0 during burst 300 SEND → immediate IDLE, no frame_done. A new frame after release starts at the ADDR burst with pixel 0.

Source files
------------

// File: rtl/oled_frame_streamer.sv
// Sends an address-window command then the RGB565 framebuffer as packed data bursts.
// Outputs are registered; each burst is held until spi_done; the RAM is read with 1-cycle latency.
module oled_frame_streamer #(
  parameter int WIDTH         = 96,
  parameter int HEIGHT        = 64,
  parameter int PIX_PER_BURST = 7,
  parameter int AW            = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic [AW-1:0] pix_addr,
  input  logic [15:0]   pix_data,
  input  logic          spi_done,
  output logic          data_type,
  output logic [3:0]    byte_count,
  output logic [119:0]  send_bytes
);

  typedef enum logic [2:0] {IDLE, ADDR, FETCH, SEND, DONE} state_t;

  localparam int IW = AW + 1;
  localparam logic [IW-1:0] TOTAL = IW'(WIDTH * HEIGHT);
  localparam logic [IW-1:0] PPB   = IW'(PIX_PER_BURST);

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, rem, idx_adv;
  logic [3:0]      cnt, cnt_nxt, n;
  logic            busy_nxt, frame_done_nxt, data_type_nxt;
  logic [AW-1:0]   pix_addr_nxt;
  logic [3:0]      byte_count_nxt;
  logic [119:0]    send_bytes_nxt;

  // Pixels in the current burst: a full burst, or whatever remains of the frame.
  assign rem     = TOTAL - idx;
  assign n       = (rem < PPB) ? 4'(rem) : 4'(PIX_PER_BURST);
  assign idx_adv = idx + IW'(n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_addr   <= '0;
      data_type  <= 1'b0;
      byte_count <= '0;
      send_bytes <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      pix_addr   <= pix_addr_nxt;
      data_type  <= data_type_nxt;
      byte_count <= byte_count_nxt;
      send_bytes <= send_bytes_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    pix_addr_nxt   = pix_addr;
    data_type_nxt  = data_type;
    byte_count_nxt = byte_count;
    send_bytes_nxt = send_bytes;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt      = ADDR;
          busy_nxt       = 1'b1;
          data_type_nxt  = 1'b0;
          byte_count_nxt = 4'd6;
          send_bytes_nxt = {8'h15, 8'h00, 8'(WIDTH - 1), 8'h75, 8'h00, 8'(HEIGHT - 1), 72'h0};
        end
      end
      ADDR: begin
        if (spi_done) begin
          state_nxt      = FETCH;
          idx_nxt        = '0;
          cnt_nxt        = '0;
          pix_addr_nxt   = '0;
          byte_count_nxt = '0;
          send_bytes_nxt = '0;
        end
      end
      FETCH: begin
        // cnt counts cycles since the first address; data for address cnt-1 is on pix_data now.
        for (int k = 0; k < PIX_PER_BURST; k++) begin
          if (cnt == 4'(k + 1)) send_bytes_nxt[119 - 16*k -: 16] = pix_data;
        end
        if (cnt + 4'd1 < n) pix_addr_nxt = pix_addr + AW'(1);
        if (cnt == n) begin
          state_nxt      = SEND;
          data_type_nxt  = 1'b1;
          byte_count_nxt = {n[2:0], 1'b0};
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SEND: begin
        if (spi_done) begin
          byte_count_nxt = '0;
          send_bytes_nxt = '0;
          data_type_nxt  = 1'b0;
          cnt_nxt        = '0;
          if (idx_adv == TOTAL) begin
            state_nxt      = DONE;
            idx_nxt        = '0;
            pix_addr_nxt   = '0;
            busy_nxt       = 1'b0;
            frame_done_nxt = 1'b1;
          end else begin
            state_nxt    = FETCH;
            idx_nxt      = idx_adv;
            pix_addr_nxt = AW'(idx_adv);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
